// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared opcode and FSM state encodings for the multiply/divide unit.
package mult_div_unit_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FIX   = 2'd2;
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction
endpackage

// File: rtl/mult_div_unit_step.sv
// mult_div_unit_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide.
module mult_div_unit_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] acc_hi,
   input  logic [W-1:0] acc_lo,
   input  logic [W-1:0] operand,
   input  logic         is_div,
   output logic [W-1:0] next_hi,
   output logic [W-1:0] next_lo
);
   logic [W:0] sum, shifted, diff;
   // Multiply consumes the multiplier from acc_lo LSB-first; divide shifts quotient bits into acc_lo.
   always_comb begin
      sum     = acc_lo[0] ? {1'b0, acc_hi} + {1'b0, operand} : {1'b0, acc_hi};
      shifted = {acc_hi, acc_lo[W-1]};
      diff    = shifted - {1'b0, operand};
      next_hi = is_div ? (diff[W] ? shifted[W-1:0] : diff[W-1:0]) : sum[W:1];
      next_lo = is_div ? {acc_lo[W-2:0], ~diff[W]} : {sum[0], acc_lo[W-1:1]};
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 33-cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   logic [1:0]    state, op_q;
   logic [CW-1:0] cnt;
   logic          neg_q, neg_rem_q, zero_q, a_neg, b_neg;
   logic [W-1:0]  acc_hi, acc_lo, opnd_q, a_q, step_hi, step_lo, abs_a, abs_b, res_hi, res_lo;
   logic [2*W-1:0] prod;
   assign busy  = state != ST_IDLE;
   assign a_neg = op_is_signed(op) & operand_a[W-1];
   assign b_neg = op_is_signed(op) & operand_b[W-1];
   assign abs_a = a_neg ? -operand_a : operand_a;
   assign abs_b = b_neg ? -operand_b : operand_b;
   mult_div_unit_step #(.W(W)) u_step (
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (opnd_q),
      .is_div  (op_is_div(op_q)),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );
   // Divide by zero bypasses sign fixing and reports the original dividend as the remainder.
   always_comb begin
      prod   = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      res_hi = !op_is_div(op_q) ? prod[2*W-1:W] : zero_q ? a_q : neg_rem_q ? -acc_hi : acc_hi;
      res_lo = !op_is_div(op_q) ? prod[W-1:0] : zero_q ? '1 : neg_q ? -acc_lo : acc_lo;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         op_q        <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         zero_q      <= 1'b0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opnd_q      <= '0;
         a_q         <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= state == ST_FIX;
         div_by_zero <= state == ST_FIX && zero_q;
         if (state == ST_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
               state     <= ST_RUN;
               op_q      <= op;
               cnt       <= '0;
               neg_q     <= a_neg ^ b_neg;
               neg_rem_q <= a_neg;
               zero_q    <= op_is_div(op) && operand_b == '0;
               acc_hi    <= '0;
               acc_lo    <= abs_a;
               opnd_q    <= abs_b;
               a_q       <= operand_a;
            end
         end else if (state == ST_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) state <= ST_FIX;
         end else begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= ST_IDLE;
         end
      end
   end
endmodule
